pconv_feeder: RTL and testbench
===============================

# pconv_feeder

Sequencer that drives the pointwise-convolution unit and collects its results for one layer pass. On `start` it walks every output channel, loads that channel's packed weights, bias and shift from parameter memory, then streams every pixel's packed input-channel vector from feature memory as single-cycle `input_vld` beats. It writes each returned `conv_dout` to output memory at `oc*PIXELS+px` and pulses `done` when the final result has been written.

## Interface
- `N`, 16, data bit width per element
- `INPUT_CHANNEL`, 3, elements per packed vector
- `OUTPUT_CHANNEL`, 4, output channels per pass
- `PIXELS`, 784, pixels per channel
- `FM_AW`, 10, feature-memory address width (≥ clog2(PIXELS))
- `OUT_AW`, 12, output-memory address width (≥ clog2(OUTPUT_CHANNEL*PIXELS))
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  one-cycle pass request; honoured only in IDLE
- `busy`  out  1  high from the cycle after an accepted `start` through the `done` cycle
- `done`  out  1  one-cycle pulse at pass completion
- `prm_rd_en`  out  1  parameter-memory read strobe
- `prm_rd_addr`  out  clog2(OUTPUT_CHANNEL)  output-channel index
- `prm_rd_weight`  in  INPUT_CHANNEL*N  packed weights; valid the cycle after `prm_rd_en`
- `prm_rd_bias`  in  32  bias; same timing
- `prm_rd_shift`  in  5  shift; same timing
- `fm_rd_en`  out  1  feature-memory read strobe
- `fm_rd_addr`  out  FM_AW  pixel index
- `fm_rd_data`  in  INPUT_CHANNEL*N  packed pixel vector; valid the cycle after `fm_rd_en`
- `input_vld`  out  1  beat strobe to the conv unit
- `input_din`  out  INPUT_CHANNEL*N  equals `fm_rd_data` when `input_vld` is high
- `weight_din`  out  INPUT_CHANNEL*N  registered weights of the current channel
- `bias_din`  out  32  registered bias
- `shift_din`  out  5  registered shift
- `conv_dout`  in  N  result from the conv unit
- `conv_dout_vld`  in  1  result strobe
- `out_wr_en`  out  1  output-memory write strobe
- `out_wr_addr`  out  OUT_AW  `oc*PIXELS+px` of the result
- `out_wr_data`  out  N  result value

## Operation
- FSM states: IDLE, LOAD, STREAM, DRAIN, DONE.
- IDLE: `start` → LOAD. Clear `oc`, `px`, result counter `rcnt` and write-address counter.
- LOAD: drive `prm_rd_en`=1 and `prm_rd_addr`=`oc` for one cycle, then go to STREAM. On that edge, latch the `prm_rd_*` data into `weight_din`, `bias_din` and `shift_din`.
- STREAM: drive `fm_rd_en`=1 and `fm_rd_addr`=`px` every cycle, and increment `px`.
  - At `px`=PIXELS-1, wrap `px` to 0.
  - If `oc`<OUTPUT_CHANNEL-1: increment `oc` and go to LOAD.
  - Otherwise go to DRAIN.
- `input_vld` is `fm_rd_en` delayed by one cycle. The last beat of a channel coincides with the next channel's LOAD cycle. The parameter registers change only on the following edge, so every beat sees its own channel's parameters.
- Result path, active in every non-IDLE state:
  - On `conv_dout_vld`: `out_wr_en`=1, `out_wr_data`=`conv_dout`, `out_wr_addr`=write counter.
  - Then increment the write counter and `rcnt`.
  - In IDLE, `conv_dout_vld` is ignored.
- DRAIN: stay until `rcnt`==OUTPUT_CHANNEL*PIXELS, then go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `start` outside IDLE is ignored.
- The conv unit's latency is not assumed. Completion is counted, never timed.

## Timing
- Reset values: all outputs 0; FSM in IDLE; all counters 0.
- Reset mid-pass returns the block to IDLE immediately. No `done` is issued, and nothing is written after reset.
- `start` sampled at edge t gives:
  - `busy` and `prm_rd_en` high in cycle t+1.
  - First `fm_rd_en` in cycle t+2.
  - First `input_vld` in cycle t+3.
- Beats within a channel are back-to-back. One idle beat cycle separates channels, caused by the LOAD cycle.
- A pass issues exactly OUTPUT_CHANNEL*PIXELS beats over OUTPUT_CHANNEL*(PIXELS+1) feed cycles.
- `out_wr_*` is registered: it appears one cycle after `conv_dout_vld`.
- `done` is asserted 2 cycles after the final `conv_dout_vld`. `busy` drops the cycle after `done`.
- `start` in the `done` cycle is ignored. `start` in the first IDLE cycle after `done` is accepted.

## Configuration
- `PCONV_FEEDER_HOLD_EN` defined:
  - Adds input `hold` (1 bit).
  - While `hold`=1 in STREAM, `fm_rd_en`=0 and `px` is frozen. The beat one cycle later is suppressed.
  - LOAD, DRAIN and the result path are unaffected.
- Undefined: no `hold` port; STREAM never stalls.

## Test plan
- OUTPUT_CHANNEL=2, PIXELS=4, INPUT_CHANNEL=3:
  - Expect `prm_rd_addr` 0 then 1.
  - Expect 8 `input_vld` beats on `fm_rd_addr` 0,1,2,3,0,1,2,3.
  - Expect `weight_din` to match channel 0 for the first 4 beats and channel 1 for the last 4.
- Start at edge 10 → `prm_rd_en` in cycle 11, `fm_rd_en` in cycle 12, `input_vld` in cycle 13. A single idle beat cycle appears between channels.
- Conv-unit model with 5-cycle latency returning value `px+16*oc`:
  - Expect 8 writes with `out_wr_addr` 0..7 and data 0,1,2,3,16,17,18,19.
  - Expect `done` 2 cycles after the last `conv_dout_vld`.
- `start` pulsed during STREAM and in the `done` cycle → no second pass, `prm_rd_en` count stays 2.
- `rst_n` low mid-STREAM:
  - Expect all outputs 0 and no `done`.
  - A fresh `start` then replays from channel 0, pixel 0.
- `PCONV_FEEDER_HOLD_EN` with `hold` high for 3 cycles during pixel 2 → `fm_rd_addr` 2 held, beat count still 8, results identical.

Source files
------------

// File: rtl/pconv_feeder.sv
// Layer-pass sequencer for the pointwise-convolution unit: loads per-channel parameters,
// streams pixel vectors, and writes results back. Optional `hold` stall: PCONV_FEEDER_HOLD_EN.
module pconv_feeder #(
    parameter int N              = 16,
    parameter int INPUT_CHANNEL  = 3,
    parameter int OUTPUT_CHANNEL = 4,
    parameter int PIXELS         = 784,
    parameter int FM_AW          = 10,
    parameter int OUT_AW         = 12,
    localparam int OC_W = (OUTPUT_CHANNEL > 1) ? $clog2(OUTPUT_CHANNEL) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
`ifdef PCONV_FEEDER_HOLD_EN
    input  logic                       hold,
`endif
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       prm_rd_en,
    output logic [OC_W-1:0]            prm_rd_addr,
    input  logic [INPUT_CHANNEL*N-1:0] prm_rd_weight,
    input  logic [31:0]                prm_rd_bias,
    input  logic [4:0]                 prm_rd_shift,
    output logic                       fm_rd_en,
    output logic [FM_AW-1:0]           fm_rd_addr,
    input  logic [INPUT_CHANNEL*N-1:0] fm_rd_data,
    output logic                       input_vld,
    output logic [INPUT_CHANNEL*N-1:0] input_din,
    output logic [INPUT_CHANNEL*N-1:0] weight_din,
    output logic [31:0]                bias_din,
    output logic [4:0]                 shift_din,
    input  logic [N-1:0]               conv_dout,
    input  logic                       conv_dout_vld,
    output logic                       out_wr_en,
    output logic [OUT_AW-1:0]          out_wr_addr,
    output logic [N-1:0]               out_wr_data
);

    localparam int TOTAL = OUTPUT_CHANNEL * PIXELS;
    localparam int RC_W  = $clog2(TOTAL + 1);

    typedef enum logic [2:0] {IDLE, LOAD, STREAM, DRAIN, DONE} state_t;

    state_t            state;
    state_t            next_state;
    logic [OC_W-1:0]   oc;
    logic [FM_AW-1:0]  px;
    logic [RC_W-1:0]   rcnt;
    logic [OUT_AW-1:0] wcnt;
    logic              prm_vld;
    logic              stall;
    logic              px_last;
    logic              oc_last;

`ifdef PCONV_FEEDER_HOLD_EN
    assign stall = hold;
`else
    assign stall = 1'b0;
`endif

    assign px_last     = (px == FM_AW'(PIXELS - 1));
    assign oc_last     = (oc == OC_W'(OUTPUT_CHANNEL - 1));
    assign prm_rd_addr = oc;
    assign fm_rd_addr  = px;
    assign input_din   = input_vld ? fm_rd_data : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        prm_rd_en  = 1'b0;
        fm_rd_en   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                busy       = 1'b1;
                prm_rd_en  = 1'b1;
                next_state = STREAM;
            end
            STREAM: begin
                busy = 1'b1;
                if (!stall) begin
                    fm_rd_en = 1'b1;
                    if (px_last) begin
                        next_state = oc_last ? DRAIN : LOAD;
                    end
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (rcnt == RC_W'(TOTAL)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Parameter memory answers one cycle after the LOAD strobe, so the latch waits
    // for that cycle; the previous channel's last beat still sees its own weights.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prm_vld    <= 1'b0;
            weight_din <= '0;
            bias_din   <= '0;
            shift_din  <= '0;
            input_vld  <= 1'b0;
        end else begin
            prm_vld   <= prm_rd_en;
            input_vld <= fm_rd_en;
            if (prm_vld) begin
                weight_din <= prm_rd_weight;
                bias_din   <= prm_rd_bias;
                shift_din  <= prm_rd_shift;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oc <= '0;
            px <= '0;
        end else if (state == IDLE) begin
            oc <= '0;
            px <= '0;
        end else if (fm_rd_en) begin
            if (px_last) begin
                px <= '0;
                if (!oc_last) begin
                    oc <= oc + OC_W'(1);
                end
            end else begin
                px <= px + FM_AW'(1);
            end
        end
    end

    // Completion is counted from returned results, never inferred from conv latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt        <= '0;
            wcnt        <= '0;
            out_wr_en   <= 1'b0;
            out_wr_addr <= '0;
            out_wr_data <= '0;
        end else if (state == IDLE) begin
            rcnt      <= '0;
            wcnt      <= '0;
            out_wr_en <= 1'b0;
        end else begin
            out_wr_en <= conv_dout_vld;
            if (conv_dout_vld) begin
                out_wr_addr <= wcnt;
                out_wr_data <= conv_dout;
                wcnt        <= wcnt + OUT_AW'(1);
                rcnt        <= rcnt + RC_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pconv_feeder.sv
// Randomized bench for pconv_feeder: memories and conv unit modelled behaviourally,
// results checked against a per-(channel,pixel) reference computed from the memory contents.
module tb_pconv_feeder;

    localparam int N      = 16;
    localparam int IC     = 3;
    localparam int OC     = 2;
    localparam int P      = 4;
    localparam int FM_AW  = 10;
    localparam int OUT_AW = 12;
    localparam int OC_W   = 1;

    logic              clk;
    logic              rst_n;
    logic              start;
`ifdef PCONV_FEEDER_HOLD_EN
    logic              hold;
`endif
    logic              busy, done;
    logic              prm_rd_en;
    logic [OC_W-1:0]   prm_rd_addr;
    logic [IC*N-1:0]   prm_rd_weight;
    logic [31:0]       prm_rd_bias;
    logic [4:0]        prm_rd_shift;
    logic              fm_rd_en;
    logic [FM_AW-1:0]  fm_rd_addr;
    logic [IC*N-1:0]   fm_rd_data;
    logic              input_vld;
    logic [IC*N-1:0]   input_din, weight_din;
    logic [31:0]       bias_din;
    logic [4:0]        shift_din;
    logic [N-1:0]      conv_dout;
    logic              conv_dout_vld;
    logic              out_wr_en;
    logic [OUT_AW-1:0] out_wr_addr;
    logic [N-1:0]      out_wr_data;

    pconv_feeder #(
        .N(N), .INPUT_CHANNEL(IC), .OUTPUT_CHANNEL(OC), .PIXELS(P),
        .FM_AW(FM_AW), .OUT_AW(OUT_AW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef PCONV_FEEDER_HOLD_EN
        .hold(hold),
`endif
        .start(start), .busy(busy), .done(done),
        .prm_rd_en(prm_rd_en), .prm_rd_addr(prm_rd_addr),
        .prm_rd_weight(prm_rd_weight), .prm_rd_bias(prm_rd_bias), .prm_rd_shift(prm_rd_shift),
        .fm_rd_en(fm_rd_en), .fm_rd_addr(fm_rd_addr), .fm_rd_data(fm_rd_data),
        .input_vld(input_vld), .input_din(input_din), .weight_din(weight_din),
        .bias_din(bias_din), .shift_din(shift_din),
        .conv_dout(conv_dout), .conv_dout_vld(conv_dout_vld),
        .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr), .out_wr_data(out_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    logic [IC*N-1:0] fmem [P];
    logic [IC*N-1:0] pw   [OC];
    logic [31:0]     pb   [OC];
    logic [4:0]      ps   [OC];

    typedef struct {int due; logic [N-1:0] val;} res_t;
    res_t pipe [$];
    int   prm_addr_q [$];
    int   fm_addr_q  [$];
    logic [N-1:0] out_val [OC*P];
    bit   out_ok [OC*P];

    int cyc = 0;
    int conv_lat = 5;
    int beat_cnt, prm_en_cnt, wr_cnt, done_cnt;
    int first_prm, first_fm, last_fm, first_vld, last_vld_cyc;
    bit done_seen;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Conv unit behaviour: per-element multiply-accumulate plus bias, then right shift.
    function automatic logic [N-1:0] conv_fn(input logic [IC*N-1:0] x, input logic [IC*N-1:0] w,
                                             input logic [31:0] b, input logic [4:0] sh);
        longint acc = 0;
        for (int i = 0; i < IC; i++) begin
            acc += longint'(x[i*N +: N]) * longint'(w[i*N +: N]);
        end
        acc += longint'(b);
        return N'(acc >> sh);
    endfunction

    task automatic randomize_mems();
        for (int i = 0; i < P; i++)
            for (int j = 0; j < IC; j++) fmem[i][j*N +: N] = N'($urandom);
        for (int i = 0; i < OC; i++) begin
            for (int j = 0; j < IC; j++) pw[i][j*N +: N] = N'($urandom);
            pb[i] = $urandom;
            ps[i] = 5'($urandom_range(0, 31));
        end
    endtask

    task automatic clear_monitor();
        beat_cnt = 0; prm_en_cnt = 0; wr_cnt = 0; done_cnt = 0; done_seen = 0;
        first_prm = -1; first_fm = -1; last_fm = -1; first_vld = -1; last_vld_cyc = -100;
        prm_addr_q.delete();
        fm_addr_q.delete();
        for (int i = 0; i < OC*P; i++) out_ok[i] = 0;
    endtask

    // Synchronous memories: address sampled at the edge, data valid the following cycle.
    always @(posedge clk) begin
        if (prm_rd_en) begin
            prm_rd_weight <= pw[prm_rd_addr];
            prm_rd_bias   <= pb[prm_rd_addr];
            prm_rd_shift  <= ps[prm_rd_addr];
            prm_en_cnt++;
            prm_addr_q.push_back(int'(prm_rd_addr));
            if (first_prm < 0) first_prm = cyc;
        end
        if (fm_rd_en) begin
            fm_rd_data <= fmem[fm_rd_addr];
            fm_addr_q.push_back(int'(fm_rd_addr));
            if (first_fm < 0) first_fm = cyc;
            last_fm = cyc;
        end
    end

    // Output monitor and fixed-latency conv unit, evaluated just after each edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (!rst_n) begin
            pipe.delete();
            conv_dout_vld = 1'b0;
            conv_dout     = '0;
        end else begin
            if (input_vld) begin
                if (first_vld < 0) first_vld = cyc;
                if (beat_cnt < OC*P) begin
                    checkOutput("beat_weight", 64'(weight_din), 64'(pw[beat_cnt / P]));
                    checkOutput("beat_input", 64'(input_din), 64'(fmem[beat_cnt % P]));
                end
                pipe.push_back('{cyc + conv_lat, conv_fn(input_din, weight_din, bias_din, shift_din)});
                beat_cnt++;
            end
            if (out_wr_en) begin
                checkOutput("wr_order", 64'(out_wr_addr), 64'(wr_cnt));
                if (int'(out_wr_addr) < OC*P) begin
                    out_val[out_wr_addr] = out_wr_data;
                    out_ok[out_wr_addr]  = 1;
                end
                wr_cnt++;
            end
            if (done) begin
                done_cnt++;
                done_seen = 1;
                checkOutput("done_latency", 64'(cyc), 64'(last_vld_cyc + 2));
            end
            conv_dout_vld = 1'b0;
            conv_dout     = '0;
            if (pipe.size() > 0 && pipe[0].due <= cyc) begin
                conv_dout_vld = 1'b1;
                conv_dout     = pipe[0].val;
                void'(pipe.pop_front());
                last_vld_cyc  = cyc;
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        checkOutput({tag, "_busy"}, 64'(busy), 0);
        checkOutput({tag, "_done"}, 64'(done), 0);
        checkOutput({tag, "_prm_en"}, 64'(prm_rd_en), 0);
        checkOutput({tag, "_prm_addr"}, 64'(prm_rd_addr), 0);
        checkOutput({tag, "_fm_en"}, 64'(fm_rd_en), 0);
        checkOutput({tag, "_fm_addr"}, 64'(fm_rd_addr), 0);
        checkOutput({tag, "_in_vld"}, 64'(input_vld), 0);
        checkOutput({tag, "_in_din"}, 64'(input_din), 0);
        checkOutput({tag, "_weight"}, 64'(weight_din), 0);
        checkOutput({tag, "_bias"}, 64'(bias_din), 0);
        checkOutput({tag, "_shift"}, 64'(shift_din), 0);
        checkOutput({tag, "_wr_en"}, 64'(out_wr_en), 0);
        checkOutput({tag, "_wr_addr"}, 64'(out_wr_addr), 0);
        checkOutput({tag, "_wr_data"}, 64'(out_wr_data), 0);
    endtask

    // Runs one pass starting at the current falling edge; returns one cycle after done.
    task automatic applyStimulus(input int lat, input bit spurious, input bit chain_out, input bit do_hold);
        int s;
        int k = 0;
        int hcnt = 0;
        bit held = 0;
        randomize_mems();
        conv_lat = lat;
        clear_monitor();
        s = cyc;
        start = 1'b1;
        while (!done_seen && k < 400) begin
            @(negedge clk);
            k++;
            start = spurious && (cyc == s + 4);
`ifdef PCONV_FEEDER_HOLD_EN
            if (hcnt > 0) begin
                checkOutput("hold_fm_en", 64'(fm_rd_en), 0);
                checkOutput("hold_fm_addr", 64'(fm_rd_addr), 2);
                hcnt--;
                if (hcnt == 0) hold = 1'b0;
            end else if (do_hold && !held && fm_rd_en && fm_rd_addr == FM_AW'(2)) begin
                hold = 1'b1;
                hcnt = 3;
                held = 1;
            end
`endif
        end
        if (!done_seen) checkOutput("done_timeout", 0, 1);
        checkOutput("done_busy", 64'(busy), 1);
        checkOutput("prm_en_count", 64'(prm_en_cnt), OC);
        for (int i = 0; i < prm_addr_q.size() && i < OC; i++)
            checkOutput("prm_addr_seq", 64'(prm_addr_q[i]), 64'(i));
        checkOutput("fm_read_count", 64'(fm_addr_q.size()), OC*P);
        for (int i = 0; i < fm_addr_q.size() && i < OC*P; i++)
            checkOutput("fm_addr_seq", 64'(fm_addr_q[i]), 64'(i % P));
        checkOutput("beat_count", 64'(beat_cnt), OC*P);
        checkOutput("write_count", 64'(wr_cnt), OC*P);
        for (int c = 0; c < OC; c++)
            for (int x = 0; x < P; x++)
                checkOutput("result", out_ok[c*P + x] ? 64'(out_val[c*P + x]) : 64'hDEAD_0000_0000_0000,
                            64'(conv_fn(fmem[x], pw[c], pb[c], ps[c])));
        checkOutput("first_prm_cycle", 64'(first_prm), 64'(s + 1));
        checkOutput("first_fm_cycle", 64'(first_fm), 64'(s + 2));
        checkOutput("first_vld_cycle", 64'(first_vld), 64'(s + 3));
        if (!do_hold) checkOutput("feed_span", 64'(last_fm - first_fm), 64'(OC*(P+1) - 2));
        start = spurious;
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_after_done", 64'(busy), 0);
        if (!chain_out) begin
            repeat (lat + 6) @(negedge clk);
            checkOutput("no_restart", 64'(prm_en_cnt), OC);
            checkOutput("done_once", 64'(done_cnt), 1);
            checkOutput("idle_busy", 64'(busy), 0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        conv_dout_vld = 1'b0;
        conv_dout = '0;
`ifdef PCONV_FEEDER_HOLD_EN
        hold = 1'b0;
`endif
        clear_monitor();
        randomize_mems();
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] pass with spurious starts in STREAM and DONE");
        applyStimulus(5, 1, 0, 0);

        $display("[TB] back-to-back passes, second started in first idle cycle");
        applyStimulus(int'($urandom_range(1, 8)), 0, 1, 0);
        applyStimulus(int'($urandom_range(1, 8)), 0, 0, 0);

        $display("[TB] reset in the middle of STREAM");
        randomize_mems();
        clear_monitor();
        conv_lat = 5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midreset");
        wr_cnt = 0;
        done_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        checkOutput("post_reset_writes", 64'(wr_cnt), 0);
        checkOutput("post_reset_done", 64'(done_cnt), 0);
        checkOutput("post_reset_busy", 64'(busy), 0);
        applyStimulus(int'($urandom_range(1, 8)), 0, 0, 0);

`ifdef PCONV_FEEDER_HOLD_EN
        $display("[TB] hold asserted for three cycles at pixel 2");
        applyStimulus(5, 0, 0, 1);
`endif

        for (int r = 0; r < 3; r++) applyStimulus(int'($urandom_range(1, 10)), 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
